// File: rtl/patgen_pkg.sv
// rtl/patgen_pkg.sv - shared constants for the display test-pattern generator
// Resolution table, pattern codes and 24-bit colour constants.
package patgen_pkg;

  typedef enum logic [2:0] {
    P_BAR    = 3'd0,
    P_RAMP   = 3'd1,
    P_CHECK  = 3'd2,
    P_LINE   = 3'd3,
    P_RED    = 3'd4,
    P_GREEN  = 3'd5,
    P_BLUE   = 3'd6,
    P_BORDER = 3'd7
  } pat_e;

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;

  // Table lookups instead of dividing HDO by 8 in hardware.
  function automatic logic [10:0] hdo_of(input logic [1:0] resol);
    case (resol)
      2'b00:   hdo_of = 11'd640;
      2'b01:   hdo_of = 11'd800;
      2'b10:   hdo_of = 11'd1024;
      default: hdo_of = 11'd1280;
    endcase
  endfunction

  function automatic logic [10:0] vdo_of(input logic [1:0] resol);
    case (resol)
      2'b00:   vdo_of = 11'd480;
      2'b01:   vdo_of = 11'd600;
      2'b10:   vdo_of = 11'd768;
      default: vdo_of = 11'd1024;
    endcase
  endfunction

  function automatic logic [10:0] barw_of(input logic [1:0] resol);
    case (resol)
      2'b00:   barw_of = 11'd80;
      2'b01:   barw_of = 11'd100;
      2'b10:   barw_of = 11'd128;
      default: barw_of = 11'd160;
    endcase
  endfunction

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = C_WHITE;
      3'd1:    bar_color = C_YELLOW;
      3'd2:    bar_color = C_CYAN;
      3'd3:    bar_color = C_GREEN;
      3'd4:    bar_color = C_MAGENTA;
      3'd5:    bar_color = C_RED;
      3'd6:    bar_color = C_BLUE;
      default: bar_color = C_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/patgen_poscnt.sv
// rtl/patgen_poscnt.sv - sync edge detection and pixel/line/bar/frame counters
// Counter values are valid for the cycle in which pre_de_i is high.
module patgen_poscnt
  import patgen_pkg::*;
#(
  parameter int CW = 11,
  parameter int FW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [1:0]    resol_i,
  input  logic [2:0]    pat_sel_i,
  input  logic          vsync_x_i,
  input  logic          pre_de_i,
  output logic [CW-1:0] xpos_o,
  output logic [CW-1:0] ypos_o,
  output logic [2:0]    bidx_o,
  output logic [FW-1:0] fcnt_o,
  output pat_e          pat_o
);

  logic          vs_d_q, pde_d_q;
  logic [CW-1:0] xpos_q, xpos_d;
  logic [CW-1:0] ypos_q, ypos_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  pat_e          pat_q, pat_d;
  logic          vfall, defall;
  logic [CW-1:0] barw_m1;

  assign vfall   = vs_d_q & ~vsync_x_i;
  assign defall  = pde_d_q & ~pre_de_i;
  assign barw_m1 = CW'(barw_of(resol_i) - 11'd1);

  always_comb begin
    xpos_d = '0;
    bcnt_d = '0;
    bidx_d = '0;
    ypos_d = ypos_q;
    fcnt_d = fcnt_q;
    pat_d  = pat_q;
    if (pre_de_i) begin
      xpos_d = xpos_q + 1'b1;
      bidx_d = bidx_q;
      if (bcnt_q == barw_m1) begin
        bcnt_d = '0;
        if (bidx_q != 3'd7) bidx_d = bidx_q + 3'd1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
    // Frame start takes priority over the end-of-line increment.
    if (vfall) begin
      ypos_d = '0;
      fcnt_d = fcnt_q + 1'b1;
      pat_d  = pat_e'(pat_sel_i);
    end else if (defall) begin
      ypos_d = ypos_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_d_q  <= 1'b1;
      pde_d_q <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      fcnt_q  <= '0;
      pat_q   <= P_BAR;
    end else begin
      vs_d_q  <= vsync_x_i;
      pde_d_q <= pre_de_i;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      fcnt_q  <= fcnt_d;
      pat_q   <= pat_d;
    end
  end

  assign xpos_o = xpos_q;
  assign ypos_o = ypos_q;
  assign bidx_o = bidx_q;
  assign fcnt_o = fcnt_q;
  assign pat_o  = pat_q;

endmodule

// File: rtl/patgen.sv
// rtl/patgen.sv - display test-pattern generator top
// Colour mux plus one register stage that keeps syncs, DE and RGB aligned.
module patgen
  import patgen_pkg::*;
#(
  parameter int CW  = 11,
  parameter int FW  = 8,
  parameter int CHK = 5
) (
  input  logic       DCLK,
  input  logic       DRST,
  input  logic [1:0] RESOL,
  input  logic [2:0] PAT_SEL,
  input  logic       DSP_HSYNC_X,
  input  logic       DSP_VSYNC_X,
  input  logic       DSP_preDE,
  output logic       DSP_HSYNC_OUT_X,
  output logic       DSP_VSYNC_OUT_X,
  output logic       DSP_DE,
  output logic [7:0] DSP_R,
  output logic [7:0] DSP_G,
  output logic [7:0] DSP_B
);

  logic [CW-1:0] xpos, ypos;
  logic [2:0]    bidx;
  logic [FW-1:0] fcnt;
  pat_e          pat;
  logic [23:0]   pat_rgb, rgb_d, rgb_q;
  logic          hs_q, vs_q, de_q;
  logic [CW-1:0] hdo_m1, vdo_m1;
  logic          on_border;

  patgen_poscnt #(.CW(CW), .FW(FW)) u_poscnt (
    .clk_i     (DCLK),
    .rst_i     (DRST),
    .resol_i   (RESOL),
    .pat_sel_i (PAT_SEL),
    .vsync_x_i (DSP_VSYNC_X),
    .pre_de_i  (DSP_preDE),
    .xpos_o    (xpos),
    .ypos_o    (ypos),
    .bidx_o    (bidx),
    .fcnt_o    (fcnt),
    .pat_o     (pat)
  );

  assign hdo_m1    = CW'(hdo_of(RESOL) - 11'd1);
  assign vdo_m1    = CW'(vdo_of(RESOL) - 11'd1);
  assign on_border = (xpos == '0) || (xpos == hdo_m1) || (ypos == '0) || (ypos == vdo_m1);

  always_comb begin
    pat_rgb = C_BLACK;
    case (pat)
      P_BAR:    pat_rgb = bar_color(bidx);
      P_RAMP:   pat_rgb = {3{xpos[7:0]}};
      P_CHECK:  pat_rgb = (xpos[CHK] ^ ypos[CHK]) ? C_BLACK : C_WHITE;
      P_LINE:   pat_rgb = (xpos == CW'({fcnt, 2'b00})) ? C_WHITE : C_BLACK;
      P_RED:    pat_rgb = C_RED;
      P_GREEN:  pat_rgb = C_GREEN;
      P_BLUE:   pat_rgb = C_BLUE;
      P_BORDER: pat_rgb = on_border ? C_WHITE : C_BLACK;
      default:  pat_rgb = C_BLACK;
    endcase
  end

  assign rgb_d = DSP_preDE ? pat_rgb : C_BLACK;

  always_ff @(posedge DCLK or posedge DRST) begin
    if (DRST) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      rgb_q <= C_BLACK;
    end else begin
      hs_q  <= DSP_HSYNC_X;
      vs_q  <= DSP_VSYNC_X;
      de_q  <= DSP_preDE;
      rgb_q <= rgb_d;
    end
  end

  assign DSP_HSYNC_OUT_X = hs_q;
  assign DSP_VSYNC_OUT_X = vs_q;
  assign DSP_DE          = de_q;
  assign DSP_R           = rgb_q[23:16];
  assign DSP_G           = rgb_q[15:8];
  assign DSP_B           = rgb_q[7:0];

endmodule

// File: tb/tb_patgen.sv
// tb/tb_patgen.sv - directed self-checking bench for patgen
// Frames are shortened vertically with one-pixel lines to reach deep rows cheaply.
module tb_patgen;

  logic       DCLK = 1'b0;
  logic       DRST;
  logic [1:0] RESOL;
  logic [2:0] PAT_SEL;
  logic       DSP_HSYNC_X, DSP_VSYNC_X, DSP_preDE;
  logic       DSP_HSYNC_OUT_X, DSP_VSYNC_OUT_X, DSP_DE;
  logic [7:0] DSP_R, DSP_G, DSP_B;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_sync = 1'b0;
  logic [23:0] line_buf [0:1279];

  typedef struct {
    logic [1:0]  resol;
    logic [2:0]  pat;
    int          row;
    int          col;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[$];

  logic [23:0] bar_tab [0:7];

  patgen dut (
    .DCLK            (DCLK),
    .DRST            (DRST),
    .RESOL           (RESOL),
    .PAT_SEL         (PAT_SEL),
    .DSP_HSYNC_X     (DSP_HSYNC_X),
    .DSP_VSYNC_X     (DSP_VSYNC_X),
    .DSP_preDE       (DSP_preDE),
    .DSP_HSYNC_OUT_X (DSP_HSYNC_OUT_X),
    .DSP_VSYNC_OUT_X (DSP_VSYNC_OUT_X),
    .DSP_DE          (DSP_DE),
    .DSP_R           (DSP_R),
    .DSP_G           (DSP_G),
    .DSP_B           (DSP_B)
  );

  always #5 DCLK = ~DCLK;

  task automatic check(input string nm, input logic [23:0] got, input logic [23:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%06h exp=%06h", nm, got, exp);
    end
  endtask

  function automatic int hdo(input logic [1:0] r);
    case (r)
      2'd0:    return 640;
      2'd1:    return 800;
      2'd2:    return 1024;
      default: return 1280;
    endcase
  endfunction

  task automatic step();
    logic hs, vs;
    hs = DSP_HSYNC_X;
    vs = DSP_VSYNC_X;
    @(posedge DCLK);
    #1;
    if (chk_sync) begin
      check("hsync_dly", {23'd0, DSP_HSYNC_OUT_X}, {23'd0, hs});
      check("vsync_dly", {23'd0, DSP_VSYNC_OUT_X}, {23'd0, vs});
    end
  endtask

  task automatic do_reset(input logic [1:0] r, input logic [2:0] p);
    DRST = 1'b1; RESOL = r; PAT_SEL = p;
    DSP_HSYNC_X = 1'b1; DSP_VSYNC_X = 1'b1; DSP_preDE = 1'b0;
    step(); step();
    DRST = 1'b0;
    step();
  endtask

  task automatic vsync_pulse();
    DSP_preDE = 1'b0;
    DSP_VSYNC_X = 1'b0; step(); step();
    DSP_VSYNC_X = 1'b1; step(); step();
  endtask

  task automatic short_line();
    DSP_preDE = 1'b1; step();
    DSP_preDE = 1'b0; DSP_HSYNC_X = 1'b0; step();
    DSP_HSYNC_X = 1'b1; step();
  endtask

  task automatic full_line(input int n);
    int de_bad;
    de_bad = 0;
    for (int i = 0; i < n; i++) begin
      DSP_preDE = 1'b1;
      step();
      line_buf[i] = {DSP_R, DSP_G, DSP_B};
      if (DSP_DE !== 1'b1) de_bad++;
    end
    DSP_preDE = 1'b0;
    step();
    check("de_low_after_line", {23'd0, DSP_DE}, 24'd0);
    check("rgb_zero_blank", {DSP_R, DSP_G, DSP_B}, 24'd0);
    check("de_high_in_line", 24'(de_bad), 24'd0);
    DSP_HSYNC_X = 1'b0; step();
    DSP_HSYNC_X = 1'b1; step();
  endtask

  task automatic run_frame(input logic [1:0] r, input logic [2:0] p, input int row);
    do_reset(r, p);
    vsync_pulse();
    for (int i = 0; i < row; i++) short_line();
    full_line(hdo(r));
  endtask

  initial begin
    bit have;
    vec_t v, last;
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00;
    bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

    vecs.push_back('{2'd0, 3'd0, 0,   0, 24'hFFFFFF});
    vecs.push_back('{2'd0, 3'd0, 0,  79, 24'hFFFFFF});
    vecs.push_back('{2'd0, 3'd0, 0,  80, 24'hFFFF00});
    vecs.push_back('{2'd0, 3'd0, 0, 160, 24'h00FFFF});
    vecs.push_back('{2'd0, 3'd0, 0, 320, 24'hFF00FF});
    vecs.push_back('{2'd0, 3'd0, 0, 639, 24'h000000});
    vecs.push_back('{2'd0, 3'd1, 0,   5, 24'h050505});
    vecs.push_back('{2'd0, 3'd1, 0, 300, 24'h2C2C2C});
    vecs.push_back('{2'd1, 3'd2, 0,  31, 24'hFFFFFF});
    vecs.push_back('{2'd1, 3'd2, 0,  32, 24'h000000});
    vecs.push_back('{2'd1, 3'd2, 32,  0, 24'h000000});
    vecs.push_back('{2'd1, 3'd2, 32, 32, 24'hFFFFFF});
    vecs.push_back('{2'd1, 3'd0, 0,  99, 24'hFFFFFF});
    vecs.push_back('{2'd1, 3'd0, 0, 100, 24'hFFFF00});
    vecs.push_back('{2'd2, 3'd7, 0,   0, 24'hFFFFFF});
    vecs.push_back('{2'd2, 3'd7, 0, 500, 24'hFFFFFF});
    vecs.push_back('{2'd2, 3'd7, 1,   0, 24'hFFFFFF});
    vecs.push_back('{2'd2, 3'd7, 1,   1, 24'h000000});
    vecs.push_back('{2'd2, 3'd7, 1, 1023, 24'hFFFFFF});
    vecs.push_back('{2'd2, 3'd7, 766, 400, 24'h000000});
    vecs.push_back('{2'd2, 3'd7, 767, 400, 24'hFFFFFF});
    vecs.push_back('{2'd2, 3'd7, 767, 1, 24'hFFFFFF});
    vecs.push_back('{2'd3, 3'd4, 0, 1279, 24'hFF0000});
    vecs.push_back('{2'd3, 3'd6, 0,  10, 24'h0000FF});
    vecs.push_back('{2'd3, 3'd7, 1, 1279, 24'hFFFFFF});
    vecs.push_back('{2'd3, 3'd7, 1, 1278, 24'h000000});
    vecs.push_back('{2'd0, 3'd3, 0,   4, 24'hFFFFFF});
    vecs.push_back('{2'd0, 3'd3, 0,   3, 24'h000000});

    DRST = 1'b1; RESOL = 2'd0; PAT_SEL = 3'd0;
    DSP_HSYNC_X = 1'b1; DSP_VSYNC_X = 1'b1; DSP_preDE = 1'b0;
    step(); step();
    check("rst_hsync", {23'd0, DSP_HSYNC_OUT_X}, 24'd1);
    check("rst_vsync", {23'd0, DSP_VSYNC_OUT_X}, 24'd1);
    check("rst_de", {23'd0, DSP_DE}, 24'd0);
    check("rst_rgb", {DSP_R, DSP_G, DSP_B}, 24'd0);

    // Mid-line asynchronous reset with syncs low and preDE high.
    DRST = 1'b0;
    DSP_preDE = 1'b1; DSP_HSYNC_X = 1'b0; DSP_VSYNC_X = 1'b0;
    for (int i = 0; i < 40; i++) step();
    check("pre_rst_de", {23'd0, DSP_DE}, 24'd1);
    check("pre_rst_hs", {23'd0, DSP_HSYNC_OUT_X}, 24'd0);
    check("pre_rst_rgb", {DSP_R, DSP_G, DSP_B}, 24'hFFFFFF);
    #2;
    DRST = 1'b1;
    #1;
    check("async_rst_hs", {23'd0, DSP_HSYNC_OUT_X}, 24'd1);
    check("async_rst_vs", {23'd0, DSP_VSYNC_OUT_X}, 24'd1);
    check("async_rst_de", {23'd0, DSP_DE}, 24'd0);
    check("async_rst_rgb", {DSP_R, DSP_G, DSP_B}, 24'd0);
    DSP_HSYNC_X = 1'b1; DSP_VSYNC_X = 1'b1;
    step();
    DRST = 1'b0;
    for (int i = 0; i < 81; i++) begin
      step();
      line_buf[i] = {DSP_R, DSP_G, DSP_B};
    end
    check("restart_px40", line_buf[40], 24'hFFFFFF);
    check("restart_px79", line_buf[79], 24'hFFFFFF);
    check("restart_px80", line_buf[80], 24'hFFFF00);
    DSP_preDE = 1'b0;
    step();

    have = 1'b0;
    foreach (vecs[k]) begin
      v = vecs[k];
      if (!have || v.resol != last.resol || v.pat != last.pat || v.row != last.row)
        run_frame(v.resol, v.pat, v.row);
      have = 1'b1;
      last = v;
      check($sformatf("vec%0d_r%0d_p%0d_y%0d_x%0d", k, v.resol, v.pat, v.row, v.col),
            line_buf[v.col], v.exp);
    end

    run_frame(2'd0, 3'd0, 0);
    for (int c = 0; c < 640; c++)
      check($sformatf("bar_px%0d", c), line_buf[c], bar_tab[c / 80]);

    do_reset(2'd0, 3'd4);
    vsync_pulse();
    full_line(8);
    check("sel45_f0", line_buf[0], 24'hFF0000);
    PAT_SEL = 3'd5;
    full_line(8);
    check("sel45_midframe", line_buf[3], 24'hFF0000);
    vsync_pulse();
    full_line(8);
    check("sel45_next", line_buf[0], 24'h00FF00);

    do_reset(2'd0, 3'd3);
    chk_sync = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      vsync_pulse();
      full_line(16);
      check($sformatf("line_f%0d_on", f), line_buf[4 * f], 24'hFFFFFF);
      check($sformatf("line_f%0d_before", f), line_buf[4 * f - 1], 24'h000000);
      check($sformatf("line_f%0d_after", f), line_buf[4 * f + 1], 24'h000000);
    end
    chk_sync = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
